// File: rtl/srt4_pkg.sv
// Shared constants and the FSM state type for the srt4 divider feeder.
// Holds the operand width, state encoding and default divider timeout.
package srt4_pkg;

    localparam int OPW             = 8;
    localparam int DEFAULT_TIMEOUT = 64;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_BEGIN   = 3'd1;
    localparam logic [2:0] ENC_HOLD_A  = 3'd2;
    localparam logic [2:0] ENC_DIVISOR = 3'd3;
    localparam logic [2:0] ENC_WAIT_Q  = 3'd4;
    localparam logic [2:0] ENC_CAP_R   = 3'd5;
    localparam logic [2:0] ENC_RESULT  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_BEGIN   = ENC_BEGIN,
        ST_HOLD_A  = ENC_HOLD_A,
        ST_DIVISOR = ENC_DIVISOR,
        ST_WAIT_Q  = ENC_WAIT_Q,
        ST_CAP_R   = ENC_CAP_R,
        ST_RESULT  = ENC_RESULT
    } state_t;

endpackage

// File: rtl/srt4_feeder_if.sv
// Bundles the operand handshake, the divider bus and the result handshake.
// The slave modport is the feeder's view; master is the surrounding system.
interface srt4_feeder_if;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid and its data stay stable until that edge.
    logic                     in_valid;
    logic                     in_ready;
    logic [srt4_pkg::OPW-1:0] in_dividend;
    logic [srt4_pkg::OPW-1:0] in_divisor;
    logic [srt4_pkg::OPW-1:0] div_inbus;
    logic                     div_begin;
    logic [srt4_pkg::OPW-1:0] div_outbus;
    logic                     div_end;
    logic                     res_valid;
    logic                     res_ready;
    logic [srt4_pkg::OPW-1:0] res_quotient;
    logic [srt4_pkg::OPW-1:0] res_remainder;
    logic                     res_err;

    modport slave (
        input  in_valid, in_dividend, in_divisor, div_outbus, div_end, res_ready,
        output in_ready, div_inbus, div_begin, res_valid, res_quotient,
               res_remainder, res_err
    );

    modport master (
        output in_valid, in_dividend, in_divisor, div_outbus, div_end, res_ready,
        input  in_ready, div_inbus, div_begin, res_valid, res_quotient,
               res_remainder, res_err
    );

endinterface

// File: rtl/srt4_feeder_timer.sv
// Saturating up-counter guarding the divider wait; cleared before each job.
// o_done flags the enabled cycle whose edge brings the count to TIMEOUT_CYCLES.
module srt4_feeder_timer #(
    parameter int TIMEOUT_CYCLES = srt4_pkg::DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_b,
    input  logic i_clear,
    input  logic i_en,
    output logic o_done
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst_b || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_done = i_en && (r_count >= CNT_MAX - CW'(1));

endmodule

// File: rtl/srt4_feeder.sv
// Operand sequencer and result capture around the srt4 divider core.
// Optional build macro SRT4_FEEDER_DIV0_CHECK_EN short-circuits zero divisors.
module srt4_feeder
    import srt4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_b,
    srt4_feeder_if.slave        bus,
    output logic                busy,
    output state_t              o_state
);

    state_t         r_state;
    logic           r_in_ready;
    logic           r_div_begin;
    logic [OPW-1:0] r_div_inbus;
    logic [OPW-1:0] r_divisor;
    logic           r_res_valid;
    logic [OPW-1:0] r_quot;
    logic [OPW-1:0] r_rem;
    logic           r_err;
    logic           r_busy;

    logic w_div0;
    logic w_tmr_clear;
    logic w_tmr_en;
    logic w_tmr_done;

`ifdef SRT4_FEEDER_DIV0_CHECK_EN
    assign w_div0 = (bus.in_divisor == '0);
`else
    assign w_div0 = 1'b0;
`endif

    // The counter is zero during the first divisor cycle and counts from there.
    assign w_tmr_clear = (r_state == ST_HOLD_A);
    assign w_tmr_en    = (r_state == ST_DIVISOR) || (r_state == ST_WAIT_Q);

    srt4_feeder_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_clear (w_tmr_clear),
        .i_en    (w_tmr_en),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_div_begin <= 1'b0;
            r_div_inbus <= '0;
            r_divisor   <= '0;
            r_res_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_divisor  <= bus.in_divisor;
                        if (w_div0) begin
                            r_quot      <= {OPW{1'b1}};
                            r_rem       <= bus.in_dividend;
                            r_err       <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_RESULT;
                        end else begin
                            r_div_begin <= 1'b1;
                            r_div_inbus <= bus.in_dividend;
                            r_state     <= ST_BEGIN;
                        end
                    end
                end
                ST_BEGIN: begin
                    r_div_begin <= 1'b0;
                    r_state     <= ST_HOLD_A;
                end
                ST_HOLD_A: begin
                    r_div_inbus <= r_divisor;
                    r_state     <= ST_DIVISOR;
                end
                // DIVISOR is the first wait cycle; div_end beats a same-cycle timeout.
                ST_DIVISOR, ST_WAIT_Q: begin
                    if (bus.div_end) begin
                        r_quot  <= bus.div_outbus;
                        r_state <= ST_CAP_R;
                    end else if (w_tmr_done) begin
                        r_quot      <= '0;
                        r_rem       <= '0;
                        r_err       <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_div_inbus <= '0;
                        r_state     <= ST_RESULT;
                    end else begin
                        r_state <= ST_WAIT_Q;
                    end
                end
                ST_CAP_R: begin
                    r_rem       <= bus.div_outbus;
                    r_res_valid <= 1'b1;
                    r_div_inbus <= '0;
                    r_state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.div_begin     = r_div_begin;
    assign bus.div_inbus     = r_div_inbus;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_quotient  = r_quot;
    assign bus.res_remainder = r_rem;
    assign bus.res_err       = r_err;
    assign busy              = r_busy;
    assign o_state           = r_state;

endmodule

// File: tb/tb_srt4_feeder.sv
// Directed plus randomized bench for srt4_feeder with a behavioural divider.
// Build with SRT4_FEEDER_DIV0_CHECK_EN defined to cover the zero-divisor bypass.
module tb_srt4_feeder;
  import srt4_pkg::*;

  localparam int TO = 64;

  logic   clk = 1'b0;
  logic   rst_b = 1'b1;
  logic   busy;
  state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected result words {err, quotient, remainder}, oldest first.
  logic [16:0] exp_q[$];

  srt4_feeder_if bus ();

  srt4_feeder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .bus     (bus),
    .busy    (busy),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_state"},     dbg_state,         ST_IDLE);
    check({pfx, "_in_ready"},  bus.in_ready,      1);
    check({pfx, "_div_begin"}, bus.div_begin,     0);
    check({pfx, "_div_inbus"}, bus.div_inbus,     0);
    check({pfx, "_res_valid"}, bus.res_valid,     0);
    check({pfx, "_quotient"},  bus.res_quotient,  0);
    check({pfx, "_remainder"}, bus.res_remainder, 0);
    check({pfx, "_res_err"},   bus.res_err,       0);
    check({pfx, "_busy"},      busy,              0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
  endtask

  // One job: divider raises div_end 'lat' cycles after the first divisor
  // cycle. Result expected 'lat'+2 cycles later, or at TO on timeout.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int lat,
                         input int hold, input bit ready_high);
    logic [7:0]  q;
    logic [7:0]  r;
    logic [16:0] exp_w;
    int          exp_cyc;
    int          bad = 0;
    int          unstable = 0;
    q = (b == 0) ? 8'hFF : a / b;
    r = (b == 0) ? a : a % b;
    if (lat < TO) begin
      exp_cyc = lat + 2;
      exp_q.push_back({1'b0, q, r});
    end else begin
      exp_cyc = TO;
      exp_q.push_back(17'h10000);
    end
    bus.res_ready = ready_high;
    wait_ready();
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    tick();
    bus.in_valid    = 1'b0;
    bus.in_dividend = 8'($urandom_range(0, 255));
    bus.in_divisor  = 8'($urandom_range(0, 255));
    check("begin_high",  bus.div_begin, 1);
    check("begin_inbus", bus.div_inbus, a);
    check("in_ready_drop", bus.in_ready, 0);
    check("busy_high", busy, 1);
    tick();
    check("hold_begin_low", bus.div_begin, 0);
    check("hold_inbus", bus.div_inbus, a);
    tick();
    check("divisor_inbus", bus.div_inbus, b);
    for (int k = 0; k <= exp_cyc; k++) begin
      if (k > 0) tick();
      if (k < exp_cyc) begin
        if (bus.res_valid !== 1'b0 || bus.div_begin !== 1'b0) bad++;
        if (bus.div_inbus !== b) bad++;
        bus.div_end    = (k == lat);
        bus.div_outbus = (k == lat) ? q : (k == lat + 1) ? r : 8'($urandom_range(0, 255));
      end
    end
    bus.div_end = 1'b0;
    check("wait_phase_clean", bad, 0);
    exp_w = exp_q.pop_front();
    check("res_valid", bus.res_valid, 1);
    check("res_err", bus.res_err, exp_w[16]);
    check("res_quotient", bus.res_quotient, exp_w[15:8]);
    check("res_remainder", bus.res_remainder, exp_w[7:0]);
    if (!ready_high) begin
      bus.in_valid    = 1'b1;
      bus.in_dividend = 8'($urandom_range(0, 255));
      bus.in_divisor  = 8'($urandom_range(1, 255));
      for (int h = 0; h < hold; h++) begin
        tick();
        if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
            {bus.res_err, bus.res_quotient, bus.res_remainder} !== exp_w) unstable++;
      end
      if (hold > 0) check("hold_stable", unstable, 0);
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
    end
    tick();
    check("post_hs_valid", bus.res_valid, 0);
    check("post_hs_err", bus.res_err, 0);
    check("post_hs_in_ready", bus.in_ready, 1);
    check("post_hs_busy", busy, 0);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = 8'h00;
    bus.in_divisor  = 8'h00;
    bus.div_outbus  = 8'h00;
    bus.div_end     = 1'b0;
    bus.res_ready   = 1'b0;
    rst_b = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst_b = 1'b0;
    tick();

    run_job(8'd101, 8'd5, 4, 0, 1'b0);
    run_job(8'd33, 8'd4, 0, 0, 1'b0);
    run_job(8'd33, 8'd4, 70, 0, 1'b0);
    run_job(8'd200, 8'd9, TO - 1, 0, 1'b0);
    run_job(8'd99, 8'd10, TO, 0, 1'b0);
    run_job(8'd60, 8'd7, 3, 10, 1'b0);

    // Reset while the feeder waits for the divider.
    wait_ready();
    bus.in_valid    = 1'b1;
    bus.in_dividend = 8'd9;
    bus.in_divisor  = 8'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("mid_state_wait", dbg_state, ST_WAIT_Q);
    rst_b = 1'b1;
    tick();
    check_reset("midreset");
    rst_b = 1'b0;
    run_job(8'd200, 8'd7, 5, 0, 1'b0);

`ifdef SRT4_FEEDER_DIV0_CHECK_EN
    wait_ready();
    bus.in_valid    = 1'b1;
    bus.in_dividend = 8'd77;
    bus.in_divisor  = 8'd0;
    tick();
    bus.in_valid = 1'b0;
    check("div0_begin_low", bus.div_begin, 0);
    check("div0_valid", bus.res_valid, 1);
    check("div0_quotient", bus.res_quotient, 8'hFF);
    check("div0_remainder", bus.res_remainder, 8'd77);
    check("div0_err", bus.res_err, 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("div0_post_valid", bus.res_valid, 0);
    check("div0_post_in_ready", bus.in_ready, 1);
`else
    run_job(8'd77, 8'd0, 3, 0, 1'b0);
`endif

    run_job(8'd50, 8'd6, 2, 0, 1'b1);
    run_job(8'd255, 8'd16, 3, 0, 1'b1);

    for (int j = 0; j < 8; j++) begin
      run_job(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
              $urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
